mux_sel_sequencer: RTL

Round-robin select sequencer that sits directly upstream of the gate-level 4:1 mux. It arbitrates four channel requests and drives the mux selects S1/S2. After a programmable settle time it samples the mux output Y and presents the sampled bit and its channel number on a valid/ready output port. This turns the combinational mux into a fair, handshaked 4-channel serial sampler.

---
 rtl/mux_seq_pkg.sv | 20 ++
 rtl/mux_sel_sequencer_rr_pick4.sv | 30 +++
 rtl/mux_sel_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer: FSM state codes,
// channel/counter widths and a one-hot helper.
package mux_seq_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int STAT_W   = 8;
  localparam int SETTLE_W = 4;

  // FSM state encoding (IDLE, SETTLE, VALID)
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] VALID  = 2'd2;

  // One-hot grant vector for a channel number
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
    return NUM_CH'(1) << c;
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_rr_pick4.sv
// rr_pick4: combinational round-robin picker over four requests.
// Returns the first requesting channel at or after ptr (ptr, ptr+1, ... mod 4).
module rr_pick4
  import mux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              any,
  output logic [CH_W-1:0]   pick
);

  logic [CH_W-1:0] idx;
  logic            found;

  // Walk the four channels starting at ptr and keep the first requester
  always_comb begin
    any   = |req;
    pick  = ptr;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + CH_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: round-robin select sequencer for a 4:1 mux.
// Arbitrates four requests, drives the mux selects, waits SETTLE_CYCLES
// (legal 1..15) and then presents the sampled Y with its channel on a
// valid/ready port. Optional per-channel accepted-sample counters are
// built when MUXSEQ_STATS_EN is defined.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              Y,
  input  logic              out_ready,
`ifdef MUXSEQ_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_count,
`endif
  output logic              S1,
  output logic              S2,
  output logic [NUM_CH-1:0] grant,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_chan,
  output logic              out_bit
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [1:0]          state;
  logic [CH_W-1:0]     chan;
  logic [CH_W-1:0]     ptr;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                pick_any;
  logic [CH_W-1:0]     pick_ch;
  logic                handshake;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr),
    .any  (pick_any),
    .pick (pick_ch)
  );

  // Selects come straight from the latched channel, so they only move on IDLE->SETTLE
  assign S1        = chan[1];
  assign S2        = chan[0];
  assign out_valid = (state == VALID);
  assign handshake = out_valid & out_ready;

  // Main sequencer FSM: pick in IDLE, count down in SETTLE, hold in VALID until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chan       <= '0;
      ptr        <= '0;
      settle_cnt <= '0;
      grant      <= '0;
      out_chan   <= '0;
      out_bit    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            chan       <= pick_ch;
            grant      <= ch_onehot(pick_ch);
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end else begin
            out_bit  <= Y;
            out_chan <= chan;
            state    <= VALID;
          end
        end
        VALID: begin
          if (out_ready) begin
            ptr   <= chan + CH_W'(1);
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef MUXSEQ_STATS_EN
  logic [STAT_W-1:0] cnt [NUM_CH];

  // Saturating per-channel accepted-sample counters; a clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (handshake && (cnt[out_chan] != {STAT_W{1'b1}})) begin
      cnt[out_chan] <= cnt[out_chan] + STAT_W'(1);
    end
  end

  assign stat_count = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule
